// File: rtl/if_id_stage_reg_if.sv
// if_id_stage_reg_if: fetch-to-decode bus; slave = pipeline register, master = driver/observer
interface if_id_stage_reg_if #(
  parameter int IW = 32,
  parameter int AW = 32,
  parameter int CW = 16
);
  logic          stall;
  logic          flush;
  logic          valid_i;
  logic [IW-1:0] instr_i;
  logic [AW-1:0] pc_i;
  logic          bd_i;
  logic          valid_o;
  logic [IW-1:0] ir_o;
  logic [AW-1:0] pc_o;
  logic [AW-1:0] pc4_o;
  logic [AW-1:0] pc8_o;
  logic          bd_o;
  logic [4:0]    exc_o;
`ifdef IF_ID_PERF_CNT_EN
  logic [CW-1:0] stall_cnt_o;
  logic [CW-1:0] flush_cnt_o;
  modport slave (
    input  stall, flush, valid_i, instr_i, pc_i, bd_i,
    output valid_o, ir_o, pc_o, pc4_o, pc8_o, bd_o, exc_o, stall_cnt_o, flush_cnt_o
  );
  modport master (
    output stall, flush, valid_i, instr_i, pc_i, bd_i,
    input  valid_o, ir_o, pc_o, pc4_o, pc8_o, bd_o, exc_o, stall_cnt_o, flush_cnt_o
  );
`else
  modport slave (
    input  stall, flush, valid_i, instr_i, pc_i, bd_i,
    output valid_o, ir_o, pc_o, pc4_o, pc8_o, bd_o, exc_o
  );
  modport master (
    output stall, flush, valid_i, instr_i, pc_i, bd_i,
    input  valid_o, ir_o, pc_o, pc4_o, pc8_o, bd_o, exc_o
  );
`endif
endinterface

// File: rtl/if_id_stage_reg.sv
// if_id_stage_reg: IF/ID pipeline register with valid, delay-slot flag, AdEL capture; IF_ID_PERF_CNT_EN adds stall/flush counters
module if_id_stage_reg #(
  parameter int            IW    = 32,
  parameter int            AW    = 32,
  parameter logic [AW-1:0] PC_LO = 'h0000_3000,
  parameter logic [AW-1:0] PC_HI = 'h0000_6FFC,
  parameter int            CW    = 16
) (
  input logic              clk,
  input logic              reset,
  if_id_stage_reg_if.slave bus
);
  logic          valid_q, valid_d;
  logic [IW-1:0] ir_q, ir_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          bd_q, bd_d;
  logic [4:0]    exc_q, exc_d;
  logic          bad;
  always_comb begin
    bad     = bus.valid_i & (bus.pc_i[1:0] != 2'b00 | bus.pc_i < PC_LO | bus.pc_i > PC_HI);
    valid_d = bus.flush ? 1'b0 : bus.stall ? valid_q : bus.valid_i;
    pc_d    = bus.flush ? '0 : bus.stall ? pc_q : bus.pc_i;
    bd_d    = bus.flush ? 1'b0 : bus.stall ? bd_q : bus.bd_i;
    ir_d    = bus.flush ? '0 : bus.stall ? ir_q : (bus.valid_i & ~bad) ? bus.instr_i : '0;
    exc_d   = bus.flush ? 5'd0 : bus.stall ? exc_q : bad ? 5'd4 : 5'd0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      ir_q    <= '0;
      pc_q    <= '0;
      bd_q    <= 1'b0;
      exc_q   <= 5'd0;
    end else begin
      valid_q <= valid_d;
      ir_q    <= ir_d;
      pc_q    <= pc_d;
      bd_q    <= bd_d;
      exc_q   <= exc_d;
    end
  end
  assign bus.valid_o = valid_q;
  assign bus.ir_o    = ir_q;
  assign bus.pc_o    = pc_q;
  assign bus.pc4_o   = pc_q + AW'(4);
  assign bus.pc8_o   = pc_q + AW'(8);
  assign bus.bd_o    = bd_q;
  assign bus.exc_o   = exc_q;
`ifdef IF_ID_PERF_CNT_EN
  logic [CW-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  always_comb begin
    stall_cnt_d = (bus.stall & ~bus.flush & ~&stall_cnt_q) ? stall_cnt_q + CW'(1) : stall_cnt_q;
    flush_cnt_d = (bus.flush & ~&flush_cnt_q) ? flush_cnt_q + CW'(1) : flush_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  assign bus.stall_cnt_o = stall_cnt_q;
  assign bus.flush_cnt_o = flush_cnt_q;
`endif
endmodule

// File: tb/tb_if_id_stage_reg.sv
// tb_if_id_stage_reg: directed-vector bench for if_id_stage_reg
module tb_if_id_stage_reg;
  localparam int IW = 32;
  localparam int AW = 32;
  localparam int CW = 4;
  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;
  always #5 clk = ~clk;
  if_id_stage_reg_if #(.IW(IW), .AW(AW), .CW(CW)) bus ();
  if_id_stage_reg #(.IW(IW), .AW(AW), .CW(CW)) dut (.clk(clk), .reset(reset), .bus(bus));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_all(input string tag, input logic v, input logic [31:0] ir, input logic [31:0] pc,
                         input logic bd, input logic [4:0] exc);
    chk({tag, ".valid"}, 32'(bus.valid_o), 32'(v));
    chk({tag, ".ir"}, bus.ir_o, ir);
    chk({tag, ".pc"}, bus.pc_o, pc);
    chk({tag, ".pc4"}, bus.pc4_o, pc + 32'd4);
    chk({tag, ".pc8"}, bus.pc8_o, pc + 32'd8);
    chk({tag, ".bd"}, 32'(bus.bd_o), 32'(bd));
    chk({tag, ".exc"}, 32'(bus.exc_o), 32'(exc));
  endtask
  logic [31:0] bad_pc [3] = '{32'h3002, 32'h2FFC, 32'h7000};
  initial begin
    reset = 1'b1;
    bus.stall = 1'b0; bus.flush = 1'b0; bus.valid_i = 1'b0;
    bus.instr_i = '0; bus.pc_i = '0; bus.bd_i = 1'b0;
    step(); step();
    chk_all("reset", 1'b0, 32'h0, 32'h0, 1'b0, 5'd0);
`ifdef IF_ID_PERF_CNT_EN
    chk("reset.scnt", 32'(bus.stall_cnt_o), 32'd0);
    chk("reset.fcnt", 32'(bus.flush_cnt_o), 32'd0);
`endif
    reset = 1'b0;
    bus.pc_i = 32'h3000; bus.instr_i = 32'h3C01_1234; bus.valid_i = 1'b1;
    step();
    chk_all("load3000", 1'b1, 32'h3C01_1234, 32'h3000, 1'b0, 5'd0);
    bus.pc_i = 32'h3004;
    step();
    chk_all("load3004", 1'b1, 32'h3C01_1234, 32'h3004, 1'b0, 5'd0);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.pc_i = 32'h3100 + 32'(i * 4); bus.instr_i = 32'hDEAD_0000 + 32'(i); bus.bd_i = 1'b1;
      step();
      chk_all("stall", 1'b1, 32'h3C01_1234, 32'h3004, 1'b0, 5'd0);
    end
`ifdef IF_ID_PERF_CNT_EN
    chk("stall.scnt", 32'(bus.stall_cnt_o), 32'd3);
`endif
    bus.flush = 1'b1;
    step();
    chk_all("flush_stall", 1'b0, 32'h0, 32'h0, 1'b0, 5'd0);
`ifdef IF_ID_PERF_CNT_EN
    chk("flush.scnt", 32'(bus.stall_cnt_o), 32'd3);
    chk("flush.fcnt", 32'(bus.flush_cnt_o), 32'd1);
`endif
    bus.stall = 1'b0; bus.flush = 1'b0; bus.bd_i = 1'b0;
    bus.valid_i = 1'b1; bus.instr_i = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      bus.pc_i = bad_pc[i];
      step();
      chk_all("adel", 1'b1, 32'h0, bad_pc[i], 1'b0, 5'd4);
    end
    bus.pc_i = 32'h6FFC;
    step();
    chk_all("pc_hi", 1'b1, 32'hFFFF_FFFF, 32'h6FFC, 1'b0, 5'd0);
    bus.valid_i = 1'b0; bus.pc_i = 32'hFFFF_FFFC;
    step();
    chk_all("wrap", 1'b0, 32'h0, 32'hFFFF_FFFC, 1'b0, 5'd0);
    bus.valid_i = 1'b1; bus.pc_i = 32'h3010; bus.bd_i = 1'b1; bus.instr_i = 32'h0000_0021;
    step();
    chk_all("bd", 1'b1, 32'h0000_0021, 32'h3010, 1'b1, 5'd0);
    bus.valid_i = 1'b0; bus.pc_i = 32'h3001; bus.bd_i = 1'b0;
    step();
    chk_all("invalid", 1'b0, 32'h0, 32'h3001, 1'b0, 5'd0);
    bus.stall = 1'b1; bus.valid_i = 1'b1; bus.pc_i = 32'h3020;
    for (int i = 0; i < 20; i++) step();
    chk_all("long_stall", 1'b0, 32'h0, 32'h3001, 1'b0, 5'd0);
`ifdef IF_ID_PERF_CNT_EN
    chk("sat.scnt", 32'(bus.stall_cnt_o), 32'd15);
    chk("sat.fcnt", 32'(bus.flush_cnt_o), 32'd1);
`endif
    reset = 1'b1;
    step();
    chk_all("reset2", 1'b0, 32'h0, 32'h0, 1'b0, 5'd0);
`ifdef IF_ID_PERF_CNT_EN
    chk("reset2.scnt", 32'(bus.stall_cnt_o), 32'd0);
    chk("reset2.fcnt", 32'(bus.flush_cnt_o), 32'd0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
